// File: rtl/dual_edge_pkg.sv
// dual_edge_pkg: definitions shared by the both-edge operator blocks.
//   op_e   : 2-bit operation select (AND, XOR, OR, AND-NOT)
//   op_bit : single-bit operation evaluator. Callers apply it per bit,
//            so it works for any operand width.
package dual_edge_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_XOR  = 2'd1,
    OP_OR   = 2'd2,
    OP_ANDN = 2'd3
  } op_e;

  function automatic logic op_bit(input op_e op, input logic x, input logic y);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = x & y;
      OP_XOR:  r = x ^ y;
      OP_OR:   r = x | y;
      OP_ANDN: r = x & ~y;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/de_sync_fifo.sv
// de_sync_fifo: posedge-only synchronous FIFO with asynchronous active-high reset.
//   clk   : clock (rising edge)
//   rst   : async active-high reset; clears pointers, count and storage
//   push  : write din at tail (ignored when full)
//   din   : write data
//   pop   : advance head (ignored when empty)
//   count : current occupancy, 0..DEPTH
//   head  : entry at the read pointer (zero after reset)
module de_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && (count != FULL);
  assign head    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (pop_ok) rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dual_edge_op_fifo.sv
// dual_edge_op_fifo: operands are captured and combined on the falling edge of
// clk; results are committed on the rising edge into a DEPTH-entry FIFO.
//   clk       : single clock, both edges used
//   rst       : async active-high reset (clears negedge and posedge state)
//   in_valid  : operand offer, sampled at negedge
//   in_ready  : FIFO not full; accept at next negedge
//   a, b, op  : operands and op select (0 and, 1 xor, 2 or, 3 and-not)
//   out_valid : FIFO non-empty
//   out_ready : consumer pop, sampled at posedge
//   f         : FIFO head result
//   xfer_cnt  : 16-bit wrapping commit counter (only with DUAL_EDGE_OP_FIFO_STATS_EN)
module dual_edge_op_fifo
  import dual_edge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f
`ifdef DUAL_EDGE_OP_FIFO_STATS_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW:0]      count;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] t;
  logic             cap_tog;
  logic             com_tog;
  logic             sv;

  always_comb begin
    res = '0;
    for (int unsigned i = 0; i < WIDTH; i++) res[i] = op_bit(op_e'(op), a[i], b[i]);
  end

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);

  // Stage-valid is set on negedge and cleared on posedge. To keep each flop on
  // a single edge, each side toggles its own bit and sv is their difference.
  assign sv = cap_tog ^ com_tog;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      t       <= '0;
      cap_tog <= 1'b0;
    end else if (in_valid && in_ready) begin
      t       <= res;
      cap_tog <= ~cap_tog;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     com_tog <= 1'b0;
    else if (sv) com_tog <= ~com_tog;
  end

  de_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sv),
    .din   (t),
    .pop   (out_ready),
    .count (count),
    .head  (f)
  );

`ifdef DUAL_EDGE_OP_FIFO_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     xfer_cnt <= '0;
    else if (sv) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dual_edge_op_fifo.sv
module tb_dual_edge_op_fifo;
  import dual_edge_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] f;
`ifdef DUAL_EDGE_OP_FIFO_STATS_EN
  logic [15:0] xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dual_edge_op_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f)
`ifdef DUAL_EDGE_OP_FIFO_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 2'd0;
    #2;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (f !== 8'h00) begin errors++; $display("FAIL reset_f: got %h expected 00", f); end
    tick();
    rst = 1'b0;
    tick();
    // offer one operand, then reset between capture and commit
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'd0;
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midflight_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midflight_in_ready: got %b expected 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midflight_late_commit: got %b expected 0", out_valid); end
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_f [4];
    exp_f[0] = 8'h30; exp_f[1] = 8'hCC; exp_f[2] = 8'hFC; exp_f[3] = 8'hC0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 8'hF0; b = 8'h3C; op = 2'(i);
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_early_valid op%0d: got %b expected 0", i, out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid op%0d: got %b expected 1", i, out_valid); end
      checks++;
      if (f !== exp_f[i]) begin errors++; $display("FAIL sweep_f op%0d: got %h expected %h", i, f, exp_f[i]); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_popped op%0d: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = 8'h10 + 8'(i); b = 8'h01; op = 2'd1;
      checks++;
      if (in_ready !== (i < 4)) begin errors++; $display("FAIL fill_in_ready i%0d: got %b expected %b", i, in_ready, (i < 4)); end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_out_valid: got %b expected 1", out_valid); end
  endtask

  task automatic test_drain();
    logic [7:0] exp_f [8];
    exp_f[0] = 8'h11; exp_f[1] = 8'h10; exp_f[2] = 8'h13; exp_f[3] = 8'h12;
    exp_f[4] = 8'h21; exp_f[5] = 8'h20; exp_f[6] = 8'h23; exp_f[7] = 8'h22;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid k%0d: got %b expected 1", k, out_valid); end
      checks++;
      if (f !== exp_f[k]) begin errors++; $display("FAIL drain_f k%0d: got %h expected %h", k, f, exp_f[k]); end
      if (k == 0) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_full: got %b expected 0", in_ready); end
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready k%0d: got %b expected 1", k, in_ready); end
        in_valid = 1'b1; a = 8'h20 + 8'(k - 1); b = 8'h01; op = 2'd1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_f [10];
    exp_f[0] = 8'h00; exp_f[1] = 8'h1E; exp_f[2] = 8'h2F; exp_f[3] = 8'h30; exp_f[4] = 8'h04;
    exp_f[5] = 8'h5A; exp_f[6] = 8'h6F; exp_f[7] = 8'h70; exp_f[8] = 8'h08; exp_f[9] = 8'h96;
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid i%0d: got %b expected 1", i - 1, out_valid); end
        checks++;
        if (f !== exp_f[i-1]) begin errors++; $display("FAIL wrap_f i%0d: got %h expected %h", i - 1, f, exp_f[i-1]); end
      end
      if (i < 10) begin
        in_valid = 1'b1; a = 8'h11 * 8'(i); b = 8'h0F; op = 2'(i % 4);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b expected 0", out_valid); end
  endtask

`ifdef DUAL_EDGE_OP_FIFO_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h01; b = 8'h02; op = 2'd2;
    for (int i = 0; i < 65537; i++) tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL stats_wrap: got %0d expected 1", xfer_cnt); end
    rst = 1'b1;
    #1;
    checks++;
    if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d expected 0", xfer_cnt); end
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_op_sweep();
    test_fill();
    test_drain();
    test_back_to_back();
`ifdef DUAL_EDGE_OP_FIFO_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
